// File: rtl/oh_pads_cfgchain_pkg.sv
// oh_pads_pkg: shared definitions for the padring configuration chain writer.
// Rev 1.0
`default_nettype none

package oh_pads_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOW  = 3'd1;
    localparam logic [2:0] ST_HIGH = 3'd2;
    localparam logic [2:0] ST_LOAD = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam bit MSB_FIRST = 1'b1;

    function automatic int nb_calc(input int n, input int cw);
        return n * cw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/oh_pads_cfgchain_if.sv
// oh_pads_cfgchain_if: host request/readback and padring chain signals.
// Rev 1.0
`default_nettype none

interface oh_pads_cfgchain_if
    import oh_pads_pkg::*;
#(
    parameter int N  = 32,
    parameter int CW = 8,
    parameter int DW = 8
);
    localparam int NB = nb_calc(N, CW);

    logic          start;
    logic [DW-1:0] div;
    logic [NB-1:0] cfg_in;
    logic          busy;
    logic          done;
    logic [NB-1:0] rdata;
    logic          cfg_sclk;
    logic          cfg_sdata;
    logic          cfg_load;
    logic          cfg_sdin;

    modport master (
        output start, div, cfg_in, cfg_sdin,
        input  busy, done, rdata, cfg_sclk, cfg_sdata, cfg_load
    );

    modport slave (
        input  start, div, cfg_in, cfg_sdin,
        output busy, done, rdata, cfg_sclk, cfg_sdata, cfg_load
    );

endinterface

`default_nettype wire

// File: rtl/oh_pads_cfgtick.sv
// oh_pads_cfgtick: loadable phase down-counter, ticks on the last cycle of a phase.
// Rev 1.0
`default_nettype none

module oh_pads_cfgtick #(
    parameter int DW = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          load_i,
    input  wire logic          en_i,
    input  wire logic [DW-1:0] val_i,
    output logic               tick_o
);

    logic [DW-1:0] cnt_q;

    // Counts val..0 so a phase is val+1 cycles; all-ones never overflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DW'(1);
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/oh_pads_cfgchain.sv
// oh_pads_cfgchain: serialises per-pad config into the padring chain and reads back the old contents.
// Rev 1.0
`default_nettype none

module oh_pads_cfgchain
    import oh_pads_pkg::*;
#(
    parameter int N  = 32,
    parameter int CW = 8,
    parameter int DW = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    oh_pads_cfgchain_if.slave bus
);

    localparam int NB = nb_calc(N, CW);
    localparam int BW = $clog2(NB + 1);

    logic [1:0]    rsync_q;
    logic          rst;
    logic [2:0]    state_q, state_d;
    logic          pend_q;
    logic [NB-1:0] shift_q, shift_d;
    logic [NB-1:0] rb_q;
    logic [DW-1:0] div_q;
    logic [BW-1:0] bitcnt_q;
    logic          tick, accept, last_bit, phase_en, sbit;
    logic          sclk_q, sclk_d, sdata_q, sdata_d, load_q, load_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [NB-1:0] rdata_q, rdata_d;

    // Assert asynchronously, release on a clean edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rsync_q <= 2'b11;
        else       rsync_q <= {rsync_q[0], 1'b0};
    end
    assign rst = rsync_q[1];

    assign accept   = (state_q == ST_IDLE) && bus.start && !pend_q;
    assign last_bit = (bitcnt_q == BW'(NB - 1));
    assign phase_en = (state_q == ST_LOW) || (state_q == ST_HIGH) || (state_q == ST_LOAD);

    oh_pads_cfgtick #(.DW(DW)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept || tick),
        .en_i   (phase_en),
        .val_i  (accept ? bus.div : div_q),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // The accepting edge only latches; LOW is entered on the following edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pend_q) state_d = ST_LOW;
            ST_LOW:  if (tick)   state_d = ST_HIGH;
            ST_HIGH: if (tick)   state_d = last_bit ? ST_LOAD : ST_LOW;
            ST_LOAD: if (tick)   state_d = ST_DONE;
            ST_DONE:             state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        if (accept) begin
            shift_d = bus.cfg_in;
        end else if ((state_q == ST_HIGH) && tick) begin
            shift_d = MSB_FIRST ? {shift_q[NB-2:0], 1'b0} : {1'b0, shift_q[NB-1:1]};
        end
    end
    assign sbit = MSB_FIRST ? shift_d[NB-1] : shift_d[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= 1'b0;
            shift_q  <= '0;
            rb_q     <= '0;
            div_q    <= '0;
            bitcnt_q <= '0;
        end else begin
            pend_q  <= accept;
            shift_q <= shift_d;
            if (accept) begin
                div_q    <= bus.div;
                bitcnt_q <= '0;
            end
            // Tail is sampled on the edge entering HIGH, before the chain shifts.
            if ((state_q == ST_LOW) && tick) begin
                rb_q <= {rb_q[NB-2:0], bus.cfg_sdin};
            end
            if ((state_q == ST_HIGH) && tick) begin
                bitcnt_q <= bitcnt_q + BW'(1);
            end
        end
    end

    always_comb begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        load_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        case (state_d)
            ST_LOW:  begin busy_d = 1'b1; sdata_d = sbit; end
            ST_HIGH: begin busy_d = 1'b1; sclk_d = 1'b1; sdata_d = sdata_q; end
            ST_LOAD: begin busy_d = 1'b1; load_d = 1'b1; end
            ST_DONE: begin done_d = 1'b1; rdata_d = rb_q; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.cfg_sclk  = sclk_q;
    assign bus.cfg_sdata = sdata_q;
    assign bus.cfg_load  = load_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_oh_pads_cfgchain.sv
// tb_oh_pads_cfgchain: scoreboard bench for the padring config chain writer.
// Rev 1.0
`default_nettype none

module tb_oh_pads_cfgchain;

    localparam int N  = 2;
    localparam int CW = 4;
    localparam int DW = 8;
    localparam int NB = 8;

    typedef struct {
        logic [NB-1:0] cfg;
        int            p;
        logic [NB-1:0] rd;
        bit            known;
        int            acc;
    } exp_t;

    logic clk;
    logic reset;
    oh_pads_cfgchain_if #(.N(N), .CW(CW), .DW(DW)) bus ();

    oh_pads_cfgchain #(.N(N), .CW(CW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            ndone = 0;
    int            toggles = 0;
    int            nrise = 0;
    logic [NB-1:0] chain;
    logic [NB-1:0] last_word;
    bit            known;

    assign bus.cfg_sdin = chain[NB-1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Chain model plus monitor: shifts on rising cfg_sclk, checks each completed transfer.
    initial begin
        logic          sclk_p, busy_p, done_p;
        int            run, loadw, busyw, phase_bad, cur_p;
        logic [NB-1:0] bits;
        exp_t          e;
        sclk_p = 0; busy_p = 0; done_p = 0;
        run = 0; loadw = 0; busyw = 0; phase_bad = 0; bits = '0;
        forever begin
            @(negedge clk);
            if (done_p) chk("done_width", int'(bus.done), 0);
            if (bus.busy && !busy_p) begin
                run = 0; loadw = 0; busyw = 0; phase_bad = 0; nrise = 0; bits = '0;
            end
            cur_p = (exp_q.size() != 0) ? exp_q[0].p : 0;
            if (bus.cfg_sclk !== sclk_p) begin
                toggles++;
                if (bus.busy && (cur_p != 0) && (run != cur_p)) phase_bad++;
                run = 1;
            end else begin
                run++;
            end
            if (bus.busy)     busyw++;
            if (bus.cfg_load) loadw++;
            if (bus.cfg_sclk && !sclk_p) begin
                bits  = {bits[NB-2:0], bus.cfg_sdata};
                chain = {chain[NB-2:0], bus.cfg_sdata};
                nrise++;
            end
            if (bus.done) begin
                ndone++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc - e.acc, 2 * NB * e.p + e.p + 1);
                    chk("sdata_bits", int'(bits), int'(e.cfg));
                    chk("sclk_rises", nrise, NB);
                    chk("load_width", loadw, e.p);
                    chk("busy_width", busyw, 2 * NB * e.p + e.p);
                    chk("phase_len_errs", phase_bad, 0);
                    if (e.known) chk("rdata", int'(bus.rdata), int'(e.rd));
                end
            end
            sclk_p = bus.cfg_sclk;
            busy_p = bus.busy;
            done_p = bus.done;
        end
    end

    task automatic issue(input logic [NB-1:0] c, input logic [DW-1:0] d);
        exp_t e;
        e.cfg = c; e.p = int'(d) + 1; e.rd = last_word; e.known = known; e.acc = 0;
        @(negedge clk);
        bus.cfg_in = c; bus.div = d; bus.start = 1'b1;
        @(posedge clk);
        #1;
        e.acc = cyc;
        exp_q.push_back(e);
        last_word = c;
        known = 1'b1;
        bus.start = 1'b0;
        bus.cfg_in = NB'($urandom);
        bus.div = DW'($urandom);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic wait_sig(input int sel, input int budget);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if ((sel == 0) && bus.cfg_sclk) break;
            if ((sel == 1) && bus.done) break;
            if ((sel == 2) && (nrise >= 4)) break;
        end
        if (n >= budget) chk("wait_timeout", sel, -1);
    endtask

    initial begin
        int n0;
        reset = 1'b1;
        bus.start = 1'b0; bus.div = '0; bus.cfg_in = '0;
        chain = 8'h3C; last_word = 8'h3C; known = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_done",  int'(bus.done), 0);
        chk("rst_rdata", int'(bus.rdata), 0);
        chk("rst_sclk",  int'(bus.cfg_sclk), 0);
        chk("rst_sdata", int'(bus.cfg_sdata), 0);
        chk("rst_load",  int'(bus.cfg_load), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_sclk_toggles", toggles, 0);
        chk("idle_busy", int'(bus.busy), 0);

        issue(8'hA5, 8'd0);
        wait_drain(200);
        issue(8'hFF, 8'd3);
        wait_drain(400);

        // Starts while shifting and while done is high must not queue a transfer.
        n0 = ndone;
        issue(NB'($urandom), 8'd1);
        wait_sig(0, 100);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_sig(1, 200);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("ignored_starts_done_count", ndone - n0, 1);
        chk("ignored_starts_busy", int'(bus.busy), 0);
        exp_q.delete();

        for (int i = 0; i < 4; i++) begin
            issue(NB'($urandom), DW'($urandom_range(0, 3)));
            wait_drain(400);
        end

        issue(8'h5A, 8'd2);
        wait_sig(2, 300);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_sclk",  int'(bus.cfg_sclk), 0);
        chk("midrst_load",  int'(bus.cfg_load), 0);
        chk("midrst_busy",  int'(bus.busy), 0);
        chk("midrst_rdata", int'(bus.rdata), 0);
        exp_q.delete();
        known = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        issue(8'h0F, 8'd1);
        wait_drain(300);
        issue(NB'($urandom), 8'd0);
        wait_drain(200);

        issue(NB'($urandom), 8'hFF);
        wait_drain(6000);
        issue(NB'($urandom), 8'd2);
        wait_drain(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
